// File: rtl/labfinal_soc_gpio_pkg.sv
// Shared constants for the GPIO PIO: register word addresses, edge-type encodings
// and the warm-up count the input edge detector must reach before it arms.
package labfinal_soc_gpio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // s1, in_sync and prev must all hold post-reset samples before an edge is trusted.
    localparam logic [1:0] WARMUP_DONE = 2'd3;

    function automatic logic [1:0] warmup_step(input logic [1:0] count);
        return (count == WARMUP_DONE) ? count : count + 2'd1;
    endfunction

endpackage

// File: rtl/labfinal_soc_gpio_sync_edge.sv
// Two-flop pin synchronizer, previous-sample flop and per-bit edge detector,
// held quiet by a warm-up counter after reset release.
module labfinal_soc_gpio_sync_edge
    import labfinal_soc_gpio_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] in_port_i,
    output logic [WIDTH-1:0] in_sync_o,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] in_sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [1:0]       warm_q;
    logic [1:0]       warm_d;
    logic             armed;

    assign warm_d = warmup_step(warm_q);
    assign armed  = (warm_q == WARMUP_DONE);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            s1_q      <= '0;
            in_sync_q <= '0;
            prev_q    <= '0;
            warm_q    <= '0;
        end else begin
            s1_q      <= in_port_i;
            in_sync_q <= s1_q;
            prev_q    <= in_sync_q;
            warm_q    <= warm_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_edge
            logic raw;
            if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
                assign raw = ~in_sync_q[gi] & prev_q[gi];
            end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
                assign raw = in_sync_q[gi] ^ prev_q[gi];
            end else begin : g_rise
                assign raw = in_sync_q[gi] & ~prev_q[gi];
            end
            assign edge_o[gi] = raw & armed;
        end
    endgenerate

    assign in_sync_o = in_sync_q;

endmodule

// File: rtl/labfinal_soc_gpio_pio.sv
// Avalon-MM GPIO slave: data/direction/mask registers, atomic set/clear, W1C edge
// capture and a registered level interrupt. Read data is combinational on address.
module labfinal_soc_gpio_pio
    import labfinal_soc_gpio_pkg::*;
#(
    parameter int               WIDTH     = 14,
    parameter logic [WIDTH-1:0] OUT_RESET = '0,
    parameter logic [WIDTH-1:0] DIR_RESET = '0,
    parameter int               EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [2:0]       address_i,
    input  logic             chipselect_i,
    input  logic             write_n_i,
    input  logic [31:0]      writedata_i,
    output logic [31:0]      readdata_o,
    input  logic [WIDTH-1:0] in_port_i,
    output logic [WIDTH-1:0] out_port_o,
    output logic [WIDTH-1:0] oe_o,
    output logic             irq_o
);

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_in;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd_val;
    logic             wr;

    labfinal_soc_gpio_sync_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .in_port_i (in_port_i),
        .in_sync_o (in_sync),
        .edge_o    (edge_raw)
    );

    generate
        if (WIDTH < 32) begin : g_wd_unused
            logic unused_wd;
            assign unused_wd = ^writedata_i[31:WIDTH];
        end
    endgenerate

    assign wr      = chipselect_i & ~write_n_i;
    assign wd      = writedata_i[WIDTH-1:0];
    assign edge_in = edge_raw & ~dir_q;  // pins driven as outputs never capture

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irqmask_d  = irqmask_q;
        edgecap_d  = edgecap_q | edge_in;
        irq_d      = |(edgecap_q & irqmask_q);
        if (wr) begin
            case (address_i)
                ADDR_DATA:    data_out_d = wd;
                ADDR_DIR:     dir_d      = wd;
                ADDR_IRQMASK: irqmask_d  = wd;
                ADDR_EDGECAP: edgecap_d  = (edgecap_q & ~wd) | edge_in;  // a new edge beats the clear
                ADDR_OUTSET:  data_out_d = data_out_q | wd;
                ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            data_out_q <= OUT_RESET;
            dir_q      <= DIR_RESET;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        rd_val = '0;
        case (address_i)
            ADDR_DATA:    rd_val = (dir_q & data_out_q) | (~dir_q & in_sync);
            ADDR_DIR:     rd_val = dir_q;
            ADDR_IRQMASK: rd_val = irqmask_q;
            ADDR_EDGECAP: rd_val = edgecap_q;
            default:      rd_val = '0;
        endcase
        readdata_o              = '0;
        readdata_o[WIDTH-1:0]   = rd_val;
    end

    assign out_port_o = data_out_q;
    assign oe_o       = dir_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_labfinal_soc_gpio_pio.sv
// Scoreboard bench for the GPIO PIO: a rising-edge instance with non-zero reset
// values and an any-edge instance share the bus and pins.
module tb_labfinal_soc_gpio_pio;
    import labfinal_soc_gpio_pkg::*;

    localparam int W = 14;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          chipselect;
    logic          write_n;
    logic [2:0]    address;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [31:0]   readdata_any;
    logic [W-1:0]  in_port;
    logic [W-1:0]  out_port;
    logic [W-1:0]  oe;
    logic [W-1:0]  out_port_any;
    logic [W-1:0]  oe_any;
    logic          irq;
    logic          irq_any;

    always #5 clk = ~clk;

    labfinal_soc_gpio_pio #(
        .WIDTH     (W),
        .OUT_RESET (14'h0A5A),
        .DIR_RESET (14'h0003),
        .EDGE_TYPE (EDGE_RISING)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .address_i    (address),
        .chipselect_i (chipselect),
        .write_n_i    (write_n),
        .writedata_i  (writedata),
        .readdata_o   (readdata),
        .in_port_i    (in_port),
        .out_port_o   (out_port),
        .oe_o         (oe),
        .irq_o        (irq)
    );

    labfinal_soc_gpio_pio #(
        .WIDTH     (W),
        .OUT_RESET (14'h0000),
        .DIR_RESET (14'h0000),
        .EDGE_TYPE (EDGE_ANY)
    ) dut_any (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .address_i    (address),
        .chipselect_i (chipselect),
        .write_n_i    (write_n),
        .writedata_i  (writedata),
        .readdata_o   (readdata_any),
        .in_port_i    (in_port),
        .out_port_o   (out_port_any),
        .oe_o         (oe_any),
        .irq_o        (irq_any)
    );

    int checks_cnt = 0;
    int errors_cnt = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            errors_cnt++;
            $display("FAIL sb_underflow: observed 0x%08h with no expectation queued", obs);
        end else begin
            e = exp_q.pop_front();
            check_value(e.tag, obs, e.val);
        end
    endtask

    // Called just after a falling edge; the write lands on the following rising edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_addr(input logic [2:0] a);
        address = a;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd_tab [8];
        rd_tab = '{32'h2, 32'h3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        in_port    = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // 1: reset state and read map
        sb_push("rst_out_port", 32'h0A5A);
        sb_push("rst_oe",       32'h0003);
        sb_push("rst_irq",      32'h0);
        sb_pop(32'(out_port));
        sb_pop(32'(oe));
        sb_pop(32'(irq));
        for (int a = 0; a < 8; a++) begin
            sb_push($sformatf("rst_rd%0d", a), rd_tab[a]);
            rd_addr(3'(a));
            sb_pop(readdata);
            @(negedge clk);
        end

        // 2: direction, data, atomic set/clear, width truncation
        bus_write(ADDR_DIR,    32'h3FFF);
        bus_write(ADDR_DATA,   32'h00F0);
        bus_write(ADDR_OUTSET, 32'h0003);
        bus_write(ADDR_OUTCLR, 32'h0030);
        sb_push("oe_all",     32'h3FFF);
        sb_push("out_c3",     32'h00C3);
        sb_push("rd_data_c3", 32'h00C3);
        sb_push("rd_outset0", 32'h0);
        sb_pop(32'(oe));
        sb_pop(32'(out_port));
        rd_addr(ADDR_DATA);
        sb_pop(readdata);
        rd_addr(ADDR_OUTSET);
        sb_pop(readdata);
        bus_write(ADDR_DATA, 32'hFFFF_FFFF);
        sb_push("rd_data_full", 32'h3FFF);
        sb_push("out_full",     32'h3FFF);
        rd_addr(ADDR_DATA);
        sb_pop(readdata);
        sb_pop(32'(out_port));

        // 3: rising edge latency, irq and W1C
        bus_write(ADDR_DIR,     32'h0);
        bus_write(ADDR_IRQMASK, 32'h1);
        sb_push("rd_irqmask", 32'h1);
        rd_addr(ADDR_IRQMASK);
        sb_pop(readdata);
        @(negedge clk);
        address = ADDR_EDGECAP;
        in_port = 14'h0001;
        sb_push("ec_k1",  32'h0);
        sb_push("ec_k2",  32'h1);
        sb_push("irq_k2", 32'h0);
        sb_push("irq_k3", 32'h1);
        repeat (2) @(negedge clk);
        sb_pop(readdata);
        @(negedge clk);
        sb_pop(readdata);
        sb_pop(32'(irq));
        @(negedge clk);
        sb_pop(32'(irq));
        bus_write(ADDR_EDGECAP, 32'h1);
        sb_push("irq_at_w1c", 32'h1);
        sb_push("ec_cleared", 32'h0);
        sb_push("irq_w1c_p1", 32'h0);
        sb_pop(32'(irq));
        sb_pop(readdata);
        @(negedge clk);
        sb_pop(32'(irq));

        // 4: falling edge ignored; rising edge coincident with W1C survives
        in_port = 14'h0000;
        sb_push("ec_fall_ignored", 32'h0);
        repeat (4) @(negedge clk);
        sb_pop(readdata);
        in_port = 14'h0001;
        sb_push("ec_edge_vs_w1c", 32'h1);
        sb_push("irq_edge_vs_w1c", 32'h1);
        repeat (2) @(negedge clk);
        bus_write(ADDR_EDGECAP, 32'h1);
        sb_pop(readdata);
        @(negedge clk);
        sb_pop(32'(irq));

        // 5: pins high through a mid-operation reset
        in_port = 14'h3FFF;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        sb_push("rst2_out_port", 32'h0A5A);
        sb_push("rst2_oe",       32'h0003);
        sb_push("rst2_irq",      32'h0);
        sb_pop(32'(out_port));
        sb_pop(32'(oe));
        sb_pop(32'(irq));
        bus_write(ADDR_IRQMASK, 32'h3FFF);
        sb_push("warm_ec",     32'h0);
        sb_push("warm_ec_any", 32'h0);
        sb_push("warm_irq",    32'h0);
        repeat (6) @(negedge clk);
        rd_addr(ADDR_EDGECAP);
        sb_pop(readdata);
        sb_pop(readdata_any);
        sb_pop(32'(irq));

        // 6: any-edge instance, output bits masked, dir change keeps capture, cs gating
        @(negedge clk);
        bus_write(ADDR_DIR,     32'h0002);
        bus_write(ADDR_EDGECAP, 32'h3FFF);
        @(negedge clk);
        sb_push("any_ec_idle", 32'h0);
        rd_addr(ADDR_EDGECAP);
        sb_pop(readdata_any);
        @(negedge clk);
        in_port = 14'h3FFC;
        sb_push("any_ec_bit0", 32'h1);
        repeat (4) @(negedge clk);
        sb_pop(readdata_any);
        bus_write(ADDR_DIR, 32'h0003);
        sb_push("any_ec_dir_kept", 32'h1);
        rd_addr(ADDR_EDGECAP);
        sb_pop(readdata_any);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b0;
        writedata  = 32'h1555;
        address    = ADDR_DATA;
        @(negedge clk);
        address    = ADDR_DIR;
        @(negedge clk);
        address    = ADDR_EDGECAP;
        @(negedge clk);
        write_n    = 1'b1;
        sb_push("nocs_out",        32'h0A5A);
        sb_push("nocs_out_any",    32'h0);
        sb_push("nocs_ec_any",     32'h1);
        sb_push("nocs_dir_any",    32'h3);
        sb_pop(32'(out_port));
        sb_pop(32'(out_port_any));
        rd_addr(ADDR_EDGECAP);
        sb_pop(readdata_any);
        rd_addr(ADDR_DIR);
        sb_pop(readdata_any);

        check_value("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
